// File: rtl/phone_in_pkg.sv
// Shared widths, defaults and types for the phone input capture path.
package phone_in_pkg;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int DEFAULT_FIFO_DEPTH      = 4;
   localparam int PHONE_BYTE_W            = 8;
   localparam int CPU_WORD_W              = 16;

   typedef logic [PHONE_BYTE_W-1:0] phone_byte_t;
   typedef logic [CPU_WORD_W-1:0]   cpu_word_t;

   function automatic cpu_word_t zext_byte(input phone_byte_t b);
      return {{(CPU_WORD_W-PHONE_BYTE_W){1'b0}}, b};
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Purpose: first-word-fall-through FIFO, head visible straight from storage.
// Latency: a push is visible at the head after the same edge that stores it.
// Backpressure: push to full without a same-cycle pop is dropped and flagged on drop.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             drop
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign do_pop  = pop_rdy && !empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push = push_vld && (!full || do_pop);
   assign drop    = push_vld && full && !do_pop;
   assign level   = count;
   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && rst) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/phone_input_capture.sv
// Purpose: synchronise and debounce 8 phone lines, queue each settled byte for the CPU.
// Latency: a steady input change reaches valid DEBOUNCE_CYCLES+3 edges after first sample.
// Backpressure: none upstream; events arriving at a full queue are dropped and flagged sticky.
module phone_input_capture
   import phone_in_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 16,
   parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PHONE_BYTE_W-1:0]       in_raw,
   input  logic                          rd_en,
   input  logic                          clr_ovf,
   output logic [CPU_WORD_W-1:0]         data_out,
   output logic                          valid,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   phone_byte_t      sync1;
   phone_byte_t      sync_q;
   phone_byte_t      sync_prev;
   phone_byte_t      stable;
   logic [CNT_W-1:0] cnt;
   logic             push_vld;
   phone_byte_t      head_dat;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_drop;

   // Accept only once the byte has differed from the settled value and held still long enough.
   assign push_vld = (sync_q != stable) && (sync_q == sync_prev) &&
                     (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= '0;
         sync_q    <= '0;
         sync_prev <= '0;
         stable    <= '0;
         cnt       <= '0;
      end else begin
         sync1     <= in_raw;
         sync_q    <= sync1;
         sync_prev <= sync_q;
         if ((sync_q == stable) || (sync_q != sync_prev)) begin
            cnt <= '0;
         end else if (push_vld) begin
            stable <= sync_q;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (PHONE_BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_dat (sync_q),
      .pop_rdy  (rd_en),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level),
      .drop     (fifo_drop)
   );

   // A drop in the same cycle as a clear must remain visible.
   always_ff @(posedge clk) begin
      if (!rst)           overflow <= 1'b0;
      else if (fifo_drop) overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) assert (!fifo_drop || fifo_full);
   end

   assign valid    = !fifo_empty;
   assign data_out = zext_byte(head_dat);
endmodule

// File: tb/tb_phone_input_capture.sv
// Directed bench for phone_input_capture with a short debounce window and a 4-deep queue.
module tb_phone_input_capture;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_raw;
   logic        rd_en;
   logic        clr_ovf;
   logic [15:0] data_out;
   logic        valid;
   logic        overflow;
   logic [2:0]  level;

   int errors = 0;
   int checks = 0;

   phone_input_capture #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (4),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_raw   (in_raw),
      .rd_en    (rd_en),
      .clr_ovf  (clr_ovf),
      .data_out (data_out),
      .valid    (valid),
      .overflow (overflow),
      .level    (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Accepted on the 7th edge after the change; one spare edge.
   task automatic settle(input logic [7:0] b);
      in_raw = b;
      tick(8);
   endtask

   initial begin
      rst = 1'b0; in_raw = 8'hFF; rd_en = 1'b0; clr_ovf = 1'b0;
      tick(3);
      chk("rst_data",  data_out, 16'h0000);
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_ovf",   16'(overflow), 16'h0);
      chk("rst_level", 16'(level), 16'h0);

      rst = 1'b1;
      tick(6);
      chk("lat_not_yet", 16'(valid), 16'h0);
      tick(1);
      chk("lat_valid", 16'(valid), 16'h1);
      chk("lat_data",  data_out, 16'h00FF);
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      chk("pop_ff_level", 16'(level), 16'h0);

      settle(8'h00);
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      chk("back_to_00_level", 16'(level), 16'h0);

      in_raw = 8'h01; tick(4);
      in_raw = 8'h00; tick(10);
      chk("glitch_valid", 16'(valid), 16'h0);
      chk("glitch_level", 16'(level), 16'h0);
      in_raw = 8'h01; tick(10);
      chk("hold01_valid", 16'(valid), 16'h1);
      chk("hold01_data",  data_out, 16'h0001);
      chk("hold01_level", 16'(level), 16'h1);
      rd_en = 1'b1; tick(1); rd_en = 1'b0;

      settle(8'h11); settle(8'h22); settle(8'h33);
      chk("ord_level3", 16'(level), 16'h3);
      chk("ord_head11", data_out, 16'h0011);
      rd_en = 1'b1; tick(1);
      chk("ord_level2", 16'(level), 16'h2);
      chk("ord_head22", data_out, 16'h0022);
      tick(1);
      chk("ord_level1", 16'(level), 16'h1);
      chk("ord_head33", data_out, 16'h0033);
      tick(1); rd_en = 1'b0;
      chk("ord_level0", 16'(level), 16'h0);
      chk("ord_valid0", 16'(valid), 16'h0);
      chk("ord_data0",  data_out, 16'h0000);

      settle(8'h01); settle(8'h02); settle(8'h03); settle(8'h04); settle(8'h05);
      chk("ovf_level", 16'(level), 16'h4);
      chk("ovf_flag",  16'(overflow), 16'h1);
      chk("ovf_head",  data_out, 16'h0001);
      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      chk("ovf_cleared", 16'(overflow), 16'h0);
      chk("ovf_level_kept", 16'(level), 16'h4);

      in_raw = 8'h06; tick(6);
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      chk("fullpp_ovf",   16'(overflow), 16'h0);
      chk("fullpp_level", 16'(level), 16'h4);
      chk("fullpp_head",  data_out, 16'h0002);
      rd_en = 1'b1; tick(3); rd_en = 1'b0;
      chk("fullpp_tail",  data_out, 16'h0006);
      chk("fullpp_level1", 16'(level), 16'h1);

      settle(8'h07); settle(8'h08); settle(8'h09);
      in_raw = 8'h0A; tick(6);
      clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
      chk("setwins_ovf",   16'(overflow), 16'h1);
      chk("setwins_level", 16'(level), 16'h4);
      chk("setwins_head",  data_out, 16'h0006);

      rd_en = 1'b1; tick(2); rd_en = 1'b0;
      chk("mid_level2", 16'(level), 16'h2);
      chk("mid_head",   data_out, 16'h0008);
      in_raw = 8'h0B; tick(3);
      rst = 1'b0; tick(1);
      chk("midrst_data",  data_out, 16'h0000);
      chk("midrst_valid", 16'(valid), 16'h0);
      chk("midrst_level", 16'(level), 16'h0);
      chk("midrst_ovf",   16'(overflow), 16'h0);
      in_raw = 8'h00; rst = 1'b1;
      tick(12);
      chk("post_rst_no_event", 16'(valid), 16'h0);
      chk("post_rst_level",    16'(level), 16'h0);

      in_raw = 8'h0C; tick(6);
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      chk("emptypp_level", 16'(level), 16'h1);
      chk("emptypp_data",  data_out, 16'h000C);
      rd_en = 1'b1; tick(2); rd_en = 1'b0;
      chk("underflow_level", 16'(level), 16'h0);
      chk("underflow_valid", 16'(valid), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
